inst_fetch_stage: RTL and testbench
===================================

# inst_fetch_stage

Instruction-fetch stage for the pipelined LoongArch CPU core. Generates the next PC, drives the instruction SRAM (synchronous read, 1-cycle latency) and holds one fetched instruction for hand-over to the decode stage over a valid/allowin handshake. Accepts taken-branch redirects from decode and discards the wrong-path instruction in flight. Sits directly upstream of decode and feeds it `{pc, inst}`.

## Interface
- `RESET_PC`, default 32'h1c00_0000: address of the first instruction fetched after reset.
- `clk` input 1: single clock, all state on rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `ds_allowin` input 1: decode can accept an instruction this cycle.
- `br_taken` input 1: decode redirects fetch this cycle; single-cycle pulse.
- `br_target` input 32: redirect address, valid when `br_taken`=1.
- `fs_to_ds_valid` output 1: `fs_to_ds_pc`/`fs_to_ds_inst` valid this cycle.
- `fs_to_ds_pc` output 32: PC of the held instruction.
- `fs_to_ds_inst` output 32: held instruction word.
- `inst_sram_en` output 1: SRAM read enable.
- `inst_sram_we` output 1: constant 0.
- `inst_sram_addr` output 32: read address.
- `inst_sram_wdata` output 32: constant 0.
- `inst_sram_rdata` input 32: data for the address presented in the previous cycle with `inst_sram_en`=1.

## Operation
- State: `pfs_valid` (fetch-issue enable), `fs_valid`, `fs_pc`, `inst_buf`, `buf_valid`.
- Reset (resetn=0, immediate): `pfs_valid`=0, `fs_valid`=0, `fs_pc`=RESET_PC-4, `buf_valid`=0, `inst_buf`=0. Outputs: `fs_to_ds_valid`=0, `inst_sram_en`=0, `fs_to_ds_pc`=RESET_PC-4.
- `pfs_valid` becomes 1 on the first rising edge with resetn=1 and then stays 1.
- `seq_pc` = `fs_pc` + 4, modulo 2^32 (32'hffff_fffc wraps to 0).
- `nextpc` = `br_taken` ? `br_target` : `seq_pc`.
- `fs_allowin` = !`fs_valid` | `ds_allowin` | `br_taken`. A branch flush frees the slot.
- `fs_to_ds_valid` = `fs_valid` & !`br_taken`. The wrong-path instruction is never handed over.
- Issue: when `pfs_valid` & `fs_allowin`, drive `inst_sram_en`=1 and `inst_sram_addr`=`nextpc`. At the edge, `fs_pc`<=`nextpc` and `fs_valid`<=1.
- Slot drain without refill: `fs_valid` & `ds_allowin` & !`pfs_valid` clears `fs_valid`. Only possible in the first cycle after reset release.
- `fs_to_ds_inst` = `buf_valid` ? `inst_buf` : `inst_sram_rdata`.
- Stall: `fs_valid` & !`ds_allowin` & !`br_taken` holds `fs_pc` and `fs_valid`. The instruction is preserved as described under Configuration.
- Branch while stalled: `br_taken`=1 with `ds_allowin`=0 still flushes and issues `br_target` in the same cycle.
- `br_target` is used unmodified. No alignment check is made; low bits are passed to the SRAM as given.

## Timing
- Redirect latency: `br_taken` in cycle N puts `br_target` on `inst_sram_addr` in cycle N. `fs_to_ds_valid`=1 with `fs_to_ds_pc`=`br_target` from cycle N+1.
- Steady state (`ds_allowin`=1, no branch): one instruction per cycle, PCs incrementing by 4.
- First valid hand-over is 2 cycles after resetn rises: edge 1 sets `pfs_valid`, edge 2 loads `fs_pc`=RESET_PC.
- Reset asserted mid-stream clears all state immediately; partial hand-overs are lost.

## Configuration
- `FS_INST_BUF_EN` defined:
  - In the first stall cycle, `inst_buf`<=`inst_sram_rdata` and `buf_valid`<=1.
  - `inst_sram_en`=0 while stalled.
  - `buf_valid` clears on hand-over or flush.
- `FS_INST_BUF_EN` undefined:
  - No buffer; `buf_valid` is tied 0.
  - While stalled, `inst_sram_en`=1 and `inst_sram_addr`=`fs_pc`, so the held instruction is re-read every cycle.
- Port-visible `fs_to_ds_*` behaviour is identical in both builds.

## Test plan
- Reset release with `ds_allowin`=1: addresses issued are 1c00_0000, 1c00_0004, 1c00_0008. `fs_to_ds_pc` follows one cycle later, with `fs_to_ds_valid` continuous.
- Stall: drop `ds_allowin` for 3 cycles while holding pc 1c00_0008 with SRAM returning 0x0280_0421. Required: `fs_to_ds_pc`/`fs_to_ds_inst` stay 1c00_0008/0x0280_0421 throughout, and no pc is skipped or duplicated after release. Run in both macro builds.
- Branch: `br_taken`=1, `br_target`=1c00_0100 while fs holds 1c00_000c. Required: `fs_to_ds_valid`=0 that cycle; next hand-over pc is 1c00_0100, followed by 1c00_0104.
- Branch during stall: `ds_allowin`=0, `br_taken`=1, target 1c00_0200. Required: the held instruction is discarded and 1c00_0200 is presented once `ds_allowin`=1.
- Wrap: `br_target`=32'hffff_fffc. Required: the next sequential pc is 32'h0000_0000.
- Async reset mid-stall: resetn=0 between edges. Required: `fs_to_ds_valid`=0 and `inst_sram_en`=0 immediately; restart from 1c00_0000.

Source files
------------

// File: rtl/inst_fetch_stage.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage
//
// Instruction-fetch stage of the pipelined LoongArch core. It generates the
// next PC, drives a synchronous-read instruction SRAM (one cycle of read
// latency), and holds one fetched instruction. That instruction is handed to
// decode over a valid/allowin handshake. A taken branch from decode redirects
// fetch in the same cycle, and the wrong-path instruction in the slot is
// discarded.
//
// Optional feature macro: FS_INST_BUF_EN
//   defined   : during a decode stall the returned instruction is captured in
//               a local buffer, and the SRAM is idle until the slot moves.
//   undefined : there is no buffer. The held PC is re-read from the SRAM on
//               every stall cycle, so the read data always matches the held PC.
//   The fs_to_ds_* behaviour seen at the ports is the same in both builds.
//
// Ports
//   clk              in   clock, all state updates on the rising edge
//   resetn           in   asynchronous active-low reset
//   ds_allowin       in   decode can accept an instruction this cycle
//   br_taken         in   single-cycle redirect pulse from decode
//   br_target [31:0] in   redirect address, used unmodified
//   fs_to_ds_valid   out  fs_to_ds_pc / fs_to_ds_inst are valid
//   fs_to_ds_pc      out  PC of the held instruction
//   fs_to_ds_inst    out  held instruction word
//   inst_sram_en     out  SRAM read enable
//   inst_sram_we     out  always 0 (fetch never writes)
//   inst_sram_addr   out  SRAM read address
//   inst_sram_wdata  out  always 0
//   inst_sram_rdata  in   data for the address presented in the previous
//                         cycle with inst_sram_en=1
// -----------------------------------------------------------------------------
module inst_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ds_allowin,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_to_ds_pc,
   output logic [31:0] fs_to_ds_inst,
   output logic        inst_sram_en,
   output logic        inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata
);

   logic        pfs_valid;
   logic        fs_valid;
   logic [31:0] fs_pc;
   logic [31:0] seq_pc;
   logic [31:0] nextpc;
   logic        fs_allowin;
   logic        issue;
   logic        stall;
   logic        buf_valid;
   logic [31:0] inst_buf;

   // A sequential PC wraps modulo 2^32, so ffff_fffc is followed by 0.
   assign seq_pc     = fs_pc + 32'd4;
   assign nextpc     = br_taken ? br_target : seq_pc;

   // A flush frees the slot even while decode is stalled.
   assign fs_allowin = !fs_valid || ds_allowin || br_taken;
   assign stall      = fs_valid && !ds_allowin && !br_taken;
   assign issue      = pfs_valid && fs_allowin;

   assign fs_to_ds_valid  = fs_valid && !br_taken;
   assign fs_to_ds_pc     = fs_pc;
   assign fs_to_ds_inst   = buf_valid ? inst_buf : inst_sram_rdata;
   assign inst_sram_we    = 1'b0;
   assign inst_sram_wdata = 32'h0000_0000;

   // --- pre-fetch / fetch slot state ---
   // pfs_valid is set on the first edge after reset and then stays set. It
   // delays the first issue by one cycle, so the first hand-over of RESET_PC
   // comes two edges after resetn rises.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pfs_valid <= 1'b0;
         fs_valid  <= 1'b0;
         fs_pc     <= RESET_PC - 32'd4;
      end else begin
         pfs_valid <= 1'b1;
         if (issue) begin
            fs_pc    <= nextpc;
            fs_valid <= 1'b1;
         end else if (fs_allowin) begin
            // The slot empties with no refill. This happens only before
            // pfs_valid is set.
            fs_valid <= 1'b0;
         end
      end
   end

`ifdef FS_INST_BUF_EN
   // --- stall capture buffer ---
   // On the first stall cycle the SRAM still returns the held instruction.
   // It is captured here, and the SRAM is idle for the rest of the stall.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         buf_valid <= 1'b0;
         inst_buf  <= 32'h0000_0000;
      end else if (fs_allowin) begin
         buf_valid <= 1'b0;
      end else if (stall && !buf_valid) begin
         inst_buf  <= inst_sram_rdata;
         buf_valid <= 1'b1;
      end
   end

   assign inst_sram_en   = issue;
   assign inst_sram_addr = nextpc;
`else
   assign buf_valid = 1'b0;
   assign inst_buf  = 32'h0000_0000;

   // While stalled, the held PC is re-read so that rdata stays on it.
   assign inst_sram_en   = issue || stall;
   assign inst_sram_addr = stall ? fs_pc : nextpc;
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_stage
//
// Self-checking bench for inst_fetch_stage. An instruction SRAM model returns
// a word derived from each address. When the SRAM is not enabled it returns a
// poison word, so a held instruction that is not preserved shows up as a
// wrong instruction.
//
// A slot-level reference model tracks three things: whether fetch has
// started, whether an instruction is held, and its PC. This model checks
// every cycle. A directed table with hand-derived hand-over PCs runs on top of
// it. An asynchronous reset is applied mid-stall, and a randomized phase
// follows.
// -----------------------------------------------------------------------------
module tb_inst_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h1c00_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ds_allowin;
   logic        br_taken;
   logic [31:0] br_target;
   logic        fs_to_ds_valid;
   logic [31:0] fs_to_ds_pc;
   logic [31:0] fs_to_ds_inst;
   logic        inst_sram_en;
   logic        inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;

   int checks   = 0;
   int failures = 0;

   // Reference model state: fetch started, slot occupied, and the slot PC.
   bit          m_started;
   bit          m_have;
   logic [31:0] m_cur;

   typedef struct {
      bit          allow;
      bit          br;
      logic [31:0] tgt;
      bit          valid;
      logic [31:0] pc;
   } vec_t;

   vec_t tbl[19];

   inst_fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .ds_allowin      (ds_allowin),
      .br_taken        (br_taken),
      .br_target       (br_target),
      .fs_to_ds_valid  (fs_to_ds_valid),
      .fs_to_ds_pc     (fs_to_ds_pc),
      .fs_to_ds_inst   (fs_to_ds_inst),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_we    (inst_sram_we),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h1c00_0008) return 32'h0280_0421;
      return (a * 32'h9e37_79b1) ^ 32'h1357_9bdf;
   endfunction

   always @(posedge clk)
      inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : 32'hdead_beef;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_started = 1'b0;
      m_have    = 1'b0;
      m_cur     = RESET_PC - 32'd4;
   endtask

   // One cycle: drive at the negedge, compare mid-cycle, then advance the model
   // across the rising edge.
   task automatic step(input bit allow, input bit br, input logic [31:0] tgt,
                       input bit use_tbl, input bit t_valid, input logic [31:0] t_pc);
      bit exp_valid;
      ds_allowin = allow;
      br_taken   = br;
      br_target  = tgt;
      #2;
      exp_valid = m_have && !br;
      check("valid", {31'b0, fs_to_ds_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
         check("pc", fs_to_ds_pc, m_cur);
         check("inst", fs_to_ds_inst, mem_word(m_cur));
      end
      check("we", {31'b0, inst_sram_we}, 32'd0);
      check("wdata", inst_sram_wdata, 32'd0);
      if (!m_started) begin
         check("en_idle", {31'b0, inst_sram_en}, 32'd0);
      end else if (br || !m_have || allow) begin
         check("en_issue", {31'b0, inst_sram_en}, 32'd1);
         check("addr_issue", inst_sram_addr, br ? tgt : m_cur + 32'd4);
      end else begin
`ifdef FS_INST_BUF_EN
         check("en_stall", {31'b0, inst_sram_en}, 32'd0);
`else
         check("en_stall", {31'b0, inst_sram_en}, 32'd1);
         check("addr_stall", inst_sram_addr, m_cur);
`endif
      end
      if (use_tbl) begin
         check("tbl_valid", {31'b0, fs_to_ds_valid}, {31'b0, t_valid});
         if (t_valid) check("tbl_pc", fs_to_ds_pc, t_pc);
      end
      @(posedge clk);
      if (!m_started) begin
         m_started = 1'b1;
      end else if (br || !m_have || allow) begin
         m_cur  = br ? tgt : m_cur + 32'd4;
         m_have = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] tmp;
      bit          r_allow;
      bit          r_br;
      logic [31:0] r_tgt;

      tbl[0]  = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0};
      tbl[1]  = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0};
      tbl[2]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h1c00_0000};
      tbl[3]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h1c00_0004};
      tbl[4]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h1c00_0008};
      tbl[5]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h1c00_0008};
      tbl[6]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h1c00_0008};
      tbl[7]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h1c00_0008};
      tbl[8]  = '{1'b1, 1'b1, 32'h1c00_0100,  1'b0, 32'h0};
      tbl[9]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h1c00_0100};
      tbl[10] = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h1c00_0104};
      tbl[11] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h1c00_0108};
      tbl[12] = '{1'b0, 1'b1, 32'h1c00_0200,  1'b0, 32'h0};
      tbl[13] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h1c00_0200};
      tbl[14] = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h1c00_0200};
      tbl[15] = '{1'b1, 1'b1, 32'hffff_fffc,  1'b0, 32'h0};
      tbl[16] = '{1'b1, 1'b0, 32'h0,          1'b1, 32'hffff_fffc};
      tbl[17] = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h0000_0000};
      tbl[18] = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h0000_0004};

      // Reset state
      resetn     = 1'b0;
      ds_allowin = 1'b0;
      br_taken   = 1'b0;
      br_target  = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      check("rst_valid", {31'b0, fs_to_ds_valid}, 32'd0);
      check("rst_en", {31'b0, inst_sram_en}, 32'd0);
      check("rst_pc", fs_to_ds_pc, RESET_PC - 32'd4);
      @(negedge clk);
      resetn = 1'b1;

      // Directed table: reset release, stall, branch, branch in stall, wrap
      for (int i = 0; i < 19; i++)
         step(tbl[i].allow, tbl[i].br, tbl[i].tgt, 1'b1, tbl[i].valid, tbl[i].pc);

      // Async reset mid-stall, asserted between edges
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      ds_allowin = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      check("arst_valid", {31'b0, fs_to_ds_valid}, 32'd0);
      check("arst_en", {31'b0, inst_sram_en}, 32'd0);
      check("arst_pc", fs_to_ds_pc, RESET_PC - 32'd4);
      @(posedge clk);
      @(negedge clk);
      check("arst_hold_valid", {31'b0, fs_to_ds_valid}, 32'd0);
      resetn = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++)
         step(tbl[i].allow, tbl[i].br, tbl[i].tgt, 1'b1, tbl[i].valid, tbl[i].pc);

      // Randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         r_allow = ($urandom_range(0, 9) < 7);
         r_br    = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 7))
            0:       r_tgt = 32'hffff_fffc;
            1:       r_tgt = $urandom;
            default: begin
               tmp   = $urandom;
               r_tgt = tmp & 32'hffff_fffc;
            end
         endcase
         step(r_allow, r_br, r_tgt, 1'b0, 1'b0, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
